// File: rtl/fma_pkg.sv
// Shared types and constants for the FMA issue/sequence controller.
package fma_pkg;

  localparam int LANES_DEFAULT = 4;
  localparam int unsigned MAX_CMD_DEFAULT = 2;

  localparam logic [31:0] CMD_FP0  = 32'd0;
  localparam logic [31:0] CMD_FP1  = 32'd1;
  localparam logic [31:0] CMD_INT8 = 32'd2;

  // One pipeline slot: valid bit plus the op attributes that travel with it.
  typedef struct packed {
    logic                     valid;
    logic [31:0]              command;
    logic                     acc_init;
    logic [LANES_DEFAULT-1:0] lane_mask;
  } stage_t;

  // Codes compare as unsigned integers, so anything above max_cmd is illegal.
  function automatic logic cmd_legal(input logic [31:0] command, input int unsigned max_cmd);
    return command <= max_cmd;
  endfunction

endpackage

// File: rtl/fma_seq_stage.sv
// One pipeline register slice: clear beats advance, otherwise hold.
module fma_seq_stage
  import fma_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   advance,
  input  stage_t load,
  output stage_t stage
);

  stage_t stage_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stage_reg <= '0;
    end else if (advance) begin
      stage_reg <= load;
    end
  end

  assign stage = stage_reg;

endmodule

// File: rtl/fma_seq.sv
// Issue/sequence controller for the M/A/D FMA pipe; the whole pipe freezes on result backpressure.
// Optional performance counters are built when FMA_SEQ_PERF_EN is defined.
module fma_seq
  import fma_pkg::*;
#(
  parameter int          LANES   = LANES_DEFAULT,
  parameter int unsigned MAX_CMD = MAX_CMD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_command,
  input  logic             req_acc_init,
  input  logic [LANES-1:0] req_lane_mask,
  input  logic             flush,
  output logic             mul_en,
  output logic [31:0]      mul_command,
  output logic             aln_en0,
  output logic [LANES-1:0] aln_en1,
  output logic [31:0]      aln_command,
  output logic             aln_reset,
  output logic             acc_zero,
  output logic             add_en,
  output logic [3:0]       add_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_command,
  output logic             cmd_err
`ifdef FMA_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_hazard
`endif
);

  // pipe[0] is the op being issued; pipe[1..3] are stages M, A, D.
  stage_t pipe [4];
  stage_t m_load;

  logic stall;
  logic hazard;
  logic advance;
  logic fire;
  logic legal;
  logic issue;
  logic cmd_err_reg;
  logic aln_reset_reg;
  logic unused_ok;

  assign stall   = pipe[3].valid & ~res_ready;
  // A non-initial op needs the previous result back in D before it enters A.
  assign hazard  = ~req_acc_init & pipe[1].valid & ~stall;
  assign req_ready = ~reset & ~flush & ~stall & ~hazard;
  assign fire    = req_valid & req_ready;
  assign legal   = cmd_legal(req_command, MAX_CMD);
  assign issue   = fire & legal;
  assign advance = ~reset & ~flush & ~stall;

  always_comb begin
    m_load = '0;
    if (issue) begin
      m_load.valid     = 1'b1;
      m_load.command   = req_command;
      m_load.acc_init  = req_acc_init;
      m_load.lane_mask = req_lane_mask;
    end
  end

  assign pipe[0] = m_load;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      fma_seq_stage u_stage (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .advance (advance),
        .load    (pipe[gi]),
        .stage   (pipe[gi+1])
      );
    end
  endgenerate

  assign mul_en      = issue;
  assign mul_command = req_command;

  assign aln_en0     = pipe[1].valid & advance;
  assign acc_zero    = aln_en0 & pipe[1].acc_init;
  assign aln_command = pipe[2].command;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign aln_en1[gi] = aln_en0 & (pipe[1].command == CMD_INT8) & pipe[1].lane_mask[gi];
    end
  endgenerate

  assign add_en      = pipe[2].valid & advance;
  assign add_sub     = 4'b0000;
  assign res_valid   = pipe[3].valid;
  assign res_command = pipe[3].command;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_err_reg <= 1'b0;
    end else begin
      cmd_err_reg <= fire & ~legal;
    end
  end

  // Accumulator clear is held through reset and lasts one extra cycle after reset or flush.
  always_ff @(posedge clk) begin
    aln_reset_reg <= reset | flush;
  end

  assign cmd_err   = cmd_err_reg;
  assign aln_reset = reset | aln_reset_reg;

  assign unused_ok = ^{pipe[2].acc_init, pipe[2].lane_mask, pipe[3].acc_init, pipe[3].lane_mask};

`ifdef FMA_SEQ_PERF_EN
  logic [31:0] perf_issued_reg;
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_hazard_reg;

  // Saturating counters; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
      perf_hazard_reg <= '0;
    end else begin
      if (issue && perf_issued_reg != '1) begin
        perf_issued_reg <= perf_issued_reg + 32'd1;
      end
      if (stall && perf_stall_reg != '1) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
      if (hazard && req_valid && !flush && perf_hazard_reg != '1) begin
        perf_hazard_reg <= perf_hazard_reg + 32'd1;
      end
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
  assign perf_hazard = perf_hazard_reg;
`endif

endmodule

// File: tb/tb_fma_seq.sv
// Self-checking bench for fma_seq: directed timing steps, then randomized traffic against a result-order model.
module tb_fma_seq;
  import fma_pkg::*;

  localparam int LANES = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_command;
  logic             req_acc_init;
  logic [LANES-1:0] req_lane_mask;
  logic             flush;
  logic             mul_en;
  logic [31:0]      mul_command;
  logic             aln_en0;
  logic [LANES-1:0] aln_en1;
  logic [31:0]      aln_command;
  logic             aln_reset;
  logic             acc_zero;
  logic             add_en;
  logic [3:0]       add_sub;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_command;
  logic             cmd_err;
`ifdef FMA_SEQ_PERF_EN
  logic [31:0]      perf_issued;
  logic [31:0]      perf_stall;
  logic [31:0]      perf_hazard;
`endif

  always #5 clk = ~clk;

  fma_seq dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_command   (req_command),
    .req_acc_init  (req_acc_init),
    .req_lane_mask (req_lane_mask),
    .flush         (flush),
    .mul_en        (mul_en),
    .mul_command   (mul_command),
    .aln_en0       (aln_en0),
    .aln_en1       (aln_en1),
    .aln_command   (aln_command),
    .aln_reset     (aln_reset),
    .acc_zero      (acc_zero),
    .add_en        (add_en),
    .add_sub       (add_sub),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_command   (res_command),
    .cmd_err       (cmd_err)
`ifdef FMA_SEQ_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_stall    (perf_stall),
    .perf_hazard   (perf_hazard)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q [$];
  logic        exp_err = 1'b0;
  logic        m_busy = 1'b0;
  logic        prev_fr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] c, input logic ai,
                        input logic [3:0] mk, input logic rr, input logic fl);
    req_valid     = v;
    req_command   = c;
    req_acc_init  = ai;
    req_lane_mask = mk;
    res_ready     = rr;
    flush         = fl;
  endtask

  // Rules that hold every cycle, plus the in-order result scoreboard.
  task automatic rules();
    logic hs, lg, stalled, exp_ready;
    logic [31:0] front;
    hs        = req_valid & req_ready;
    lg        = (req_command <= 32'd2);
    stalled   = res_valid & ~res_ready;
    exp_ready = ~reset & ~flush & ~stalled & ~(~req_acc_init & m_busy);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("mul_en", 32'(mul_en), 32'(hs & lg));
    if (mul_en) chk("mul_command", mul_command, req_command);
    chk("cmd_err", 32'(cmd_err), 32'(exp_err));
    chk("aln_reset", 32'(aln_reset), 32'(reset | prev_fr));
    chk("add_sub", 32'(add_sub), 32'd0);
    if (stalled | flush | reset)
      chk("frozen_en", 32'({mul_en, aln_en0, add_en, aln_en1}), 32'd0);
    if (sb_q.size() == 0) chk("no_phantom", 32'(res_valid), 32'd0);
    if (res_valid && res_ready && sb_q.size() > 0) begin
      front = sb_q.pop_front();
      chk("res_order", res_command, front);
      $display("result popped: command=%0d", res_command);
    end
    if (hs & lg) sb_q.push_back(req_command);
    if (reset | flush) sb_q.delete();
    exp_err = hs & ~lg;
    prev_fr = reset | flush;
    if (reset | flush) m_busy = 1'b0;
    else if (!stalled) m_busy = hs & lg;
  endtask

  task automatic settle();
    @(negedge clk);
    rules();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 32'd0, 1'b1, 4'hF, 1'b1, 1'b0);
      settle();
      tick();
    end
  endtask

  initial begin
    logic        v, ai, rr, fl;
    logic [31:0] c;
    logic [3:0]  mk;
    int unsigned r;

    // Reset, with a request presented that must not be taken.
    reset = 1'b1;
    set_in(1'b1, 32'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_command", res_command, 32'd0);
      chk("rst_aln_command", aln_command, 32'd0);
      chk("rst_cmd_err", 32'(cmd_err), 32'd0);
      tick();
    end
    reset = 1'b0;
    idle(2);

    // Four independent back-to-back ops.
    for (int k = 0; k < 8; k++) begin
      set_in(k < 4, CMD_FP0, 1'b1, 4'hF, 1'b1, 1'b0);
      settle();
      chk("t1_ready", 32'(req_ready), 32'd1);
      chk("t1_mul_en", 32'(mul_en), 32'(k < 4));
      chk("t1_aln_en0", 32'(aln_en0), 32'(k >= 1 && k <= 4));
      chk("t1_acc_zero", 32'(acc_zero), 32'(k >= 1 && k <= 4));
      chk("t1_add_en", 32'(add_en), 32'(k >= 2 && k <= 5));
      chk("t1_res_valid", 32'(res_valid), 32'(k >= 3 && k <= 6));
      tick();
    end
    idle(2);

    // Dependent op right behind its predecessor: one bubble.
    set_in(1'b1, CMD_FP0, 1'b1, 4'hF, 1'b1, 1'b0);
    settle(); chk("t2_first_ready", 32'(req_ready), 32'd1); tick();
    set_in(1'b1, CMD_FP1, 1'b0, 4'hF, 1'b1, 1'b0);
    settle(); chk("t2_hazard_ready", 32'(req_ready), 32'd0); tick();
    settle(); chk("t2_accept_ready", 32'(req_ready), 32'd1); tick();
    set_in(1'b0, 32'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    settle();
    chk("t2_aln_en0", 32'(aln_en0), 32'd1);
    chk("t2_acc_zero", 32'(acc_zero), 32'd0);
    tick();
    idle(5);

    // Lane mask only reaches aln_en1 for the INT8 command.
    set_in(1'b1, CMD_INT8, 1'b1, 4'b0101, 1'b1, 1'b0);
    settle(); tick();
    set_in(1'b1, CMD_FP0, 1'b1, 4'b1111, 1'b1, 1'b0);
    settle();
    chk("t3_int8_en0", 32'(aln_en0), 32'd1);
    chk("t3_int8_en1", 32'(aln_en1), 32'b0101);
    tick();
    set_in(1'b0, 32'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    settle();
    chk("t3_fp_en0", 32'(aln_en0), 32'd1);
    chk("t3_fp_en1", 32'(aln_en1), 32'd0);
    tick();
    idle(5);

    // Backpressure with three ops in flight, then in-order drain.
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 32'(k), 1'b1, 4'hF, 1'b1, 1'b0);
      settle(); tick();
    end
    for (int k = 3; k < 8; k++) begin
      set_in(1'b0, 32'd0, 1'b1, 4'hF, 1'b0, 1'b0);
      settle();
      chk("t4_frozen", 32'({mul_en, aln_en0, add_en, aln_en1}), 32'd0);
      chk("t4_res_valid", 32'(res_valid), 32'd1);
      chk("t4_res_command", res_command, 32'd0);
      chk("t4_aln_command", aln_command, 32'd1);
      tick();
    end
    for (int k = 8; k < 11; k++) begin
      set_in(1'b0, 32'd0, 1'b1, 4'hF, 1'b1, 1'b0);
      settle();
      chk("t4_drain_valid", 32'(res_valid), 32'd1);
      chk("t4_drain_command", res_command, 32'(k - 8));
      if (k == 8) begin
        chk("t4_release_aln", 32'(aln_en0), 32'd1);
        chk("t4_release_add", 32'(add_en), 32'd1);
      end
      tick();
    end
    settle(); chk("t4_empty", 32'(res_valid), 32'd0); tick();
    idle(2);

    // Illegal command: accepted, nothing issued, one-cycle error pulse.
    set_in(1'b1, 32'd7, 1'b1, 4'hF, 1'b1, 1'b0);
    settle();
    chk("t5_ready", 32'(req_ready), 32'd1);
    chk("t5_mul_en", 32'(mul_en), 32'd0);
    tick();
    set_in(1'b0, 32'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    settle(); chk("t5_err_pulse", 32'(cmd_err), 32'd1); tick();
    settle(); chk("t5_err_end", 32'(cmd_err), 32'd0); tick();
    for (int k = 0; k < 4; k++) begin
      settle(); chk("t5_no_result", 32'(res_valid), 32'd0); tick();
    end

    // Flush during a stall with three ops in flight and a request presented.
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 32'(k), 1'b1, 4'hF, 1'b1, 1'b0);
      settle(); tick();
    end
    set_in(1'b1, CMD_FP0, 1'b1, 4'hF, 1'b0, 1'b1);
    settle();
    chk("t6_ready", 32'(req_ready), 32'd0);
    chk("t6_mul_en", 32'(mul_en), 32'd0);
    chk("t6_pre_valid", 32'(res_valid), 32'd1);
    tick();
    set_in(1'b0, 32'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    settle();
    chk("t6_res_valid", 32'(res_valid), 32'd0);
    chk("t6_aln_reset", 32'(aln_reset), 32'd1);
    chk("t6_pipe_idle", 32'({aln_en0, add_en}), 32'd0);
    tick();
    settle(); chk("t6_aln_reset_end", 32'(aln_reset), 32'd0); tick();
    idle(2);

    // Reset in the middle of traffic.
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 32'(k + 1), 1'b1, 4'hF, 1'b1, 1'b0);
      settle(); tick();
    end
    reset = 1'b1;
    set_in(1'b1, CMD_FP0, 1'b1, 4'hF, 1'b1, 1'b0);
    settle(); chk("t7_ready", 32'(req_ready), 32'd0); tick();
    reset = 1'b0;
    set_in(1'b0, 32'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    settle();
    chk("t7_res_valid", 32'(res_valid), 32'd0);
    chk("t7_aln_command", aln_command, 32'd0);
    tick();
    idle(2);

    // Randomized traffic with backpressure, illegal codes and occasional flush.
    for (int k = 0; k < 400; k++) begin
      v  = ($urandom_range(0, 9) < 7);
      r  = $urandom_range(0, 15);
      c  = (r < 12) ? 32'(r % 3) : ((r < 14) ? 32'(r) : 32'hFFFF_FFF0 + 32'(r));
      ai = ($urandom_range(0, 1) == 1);
      mk = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 49) == 0);
      set_in(v, c, ai, mk, rr, fl);
      settle();
      tick();
    end
    idle(8);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
